// File: rtl/bano_arbiter.sv
// bano_arbiter
//   Shares one batch-norm output path between NUM_REQ PE-cluster streams.
//   Round-robin, burst-limited grants. Every accepted word is arithmetically
//   right-shifted by the granted requester's shift amount and then lands in a
//   single registered enable/data stream toward the output buffer.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   cfg_we_i     shift-register write strobe
//   cfg_sel_i    requester index for the config write (out-of-range ignored)
//   cfg_shift_i  shift amount to store
//   req_enable_i per-requester valid
//   req_data_i   per-requester data, requester k at [k*DATA_BITWIDTH +: DATA_BITWIDTH]
//   req_ready_o  per-requester ready (at most one bit high)
//   enable_o     output valid (registered)
//   data_o       shifted output word (registered)
//   ready_i      downstream ready
//   grant_o      one-hot current grant, zero when idle
//   busy_o       high while a grant is held
module bano_arbiter #(
  parameter int DATA_BITWIDTH  = 20,
  parameter int NUM_REQ        = 4,
  parameter int BURST_LEN      = 8,
  parameter int SHIFT_BITWIDTH = 5
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               cfg_we_i,
  input  logic [$clog2(NUM_REQ)-1:0]         cfg_sel_i,
  input  logic [SHIFT_BITWIDTH-1:0]          cfg_shift_i,
  input  logic [NUM_REQ-1:0]                 req_enable_i,
  input  logic [NUM_REQ*DATA_BITWIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic                               enable_o,
  output logic [DATA_BITWIDTH-1:0]           data_o,
  input  logic                               ready_i,
  output logic [NUM_REQ-1:0]                 grant_o,
  output logic                               busy_o
);

  localparam int SEL_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [SEL_W:0] NUM_REQ_W = (SEL_W+1)'(NUM_REQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                      state_reg;
  logic [SEL_W-1:0]            grant_idx_reg;
  logic [SEL_W-1:0]            rr_ptr_reg;
  logic [CNT_W-1:0]            burst_cnt_reg;
  logic [SHIFT_BITWIDTH-1:0]   shift_reg [NUM_REQ];
  logic                        out_en_reg;
  logic [DATA_BITWIDTH-1:0]    out_data_reg;

  logic [DATA_BITWIDTH-1:0]    data_arr [NUM_REQ];

  // Per-requester slices, shift registers, grant and ready decode
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi]    = req_data_i[gi*DATA_BITWIDTH +: DATA_BITWIDTH];
      assign grant_o[gi]     = (state_reg == GRANT) && (grant_idx_reg == SEL_W'(gi));
      assign req_ready_o[gi] = grant_o[gi] && (!out_en_reg || ready_i);

      // Equality decode means an index >= NUM_REQ matches no register.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          shift_reg[gi] <= '0;
        end else if (cfg_we_i && (cfg_sel_i == SEL_W'(gi))) begin
          shift_reg[gi] <= cfg_shift_i;
        end
      end
    end
  endgenerate

  // Round-robin pick: first set request at or above the pointer, wrapping.
  // Walking offsets from high to low lets the smallest offset win.
  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W:0]   cand;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_reg} + (SEL_W+1)'(i);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (req_enable_i[cand[SEL_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[SEL_W-1:0];
      end
    end
  end

  // Granted-requester datapath
  logic                             gnt_active;
  logic                             g_enable;
  logic                             xfer;
  logic                             last_word;
  logic                             release_grant;
  logic [CNT_W-1:0]                 cnt_inc;
  logic signed [DATA_BITWIDTH-1:0]  g_word;
  logic [SHIFT_BITWIDTH-1:0]        g_shift;
  logic signed [DATA_BITWIDTH-1:0]  shifted_word;
  logic [SEL_W:0]                   g_plus_one;
  logic [SEL_W-1:0]                 ptr_next;

  assign gnt_active    = (state_reg == GRANT);
  assign g_enable      = req_enable_i[grant_idx_reg];
  assign xfer          = gnt_active && g_enable && (!out_en_reg || ready_i);
  assign cnt_inc       = burst_cnt_reg + CNT_W'(1);
  assign last_word     = (cnt_inc == CNT_W'(BURST_LEN));
  // A requester held off only by downstream backpressure keeps its grant.
  assign release_grant = gnt_active && (!g_enable || (xfer && last_word));

  assign g_word  = data_arr[grant_idx_reg];
  assign g_shift = shift_reg[grant_idx_reg];
  // Arithmetic shift sign-fills, so amounts >= DATA_BITWIDTH give 0 or -1.
  assign shifted_word = g_word >>> g_shift;

  assign g_plus_one = {1'b0, grant_idx_reg} + (SEL_W+1)'(1);
  assign ptr_next   = (g_plus_one == NUM_REQ_W) ? '0 : g_plus_one[SEL_W-1:0];

  // Arbiter FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      grant_idx_reg <= '0;
      rr_ptr_reg    <= '0;
      burst_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_reg     <= GRANT;
            grant_idx_reg <= pick_idx;
            burst_cnt_reg <= '0;
          end
        end
        GRANT: begin
          if (xfer) begin
            burst_cnt_reg <= cnt_inc;
          end
          if (release_grant) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= ptr_next;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Output register drains independently of the arbiter state; a drain and a
  // new transfer in the same cycle simply reload it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_en_reg   <= 1'b0;
      out_data_reg <= '0;
    end else if (xfer) begin
      out_en_reg   <= 1'b1;
      out_data_reg <= shifted_word;
    end else if (ready_i) begin
      out_en_reg   <= 1'b0;
    end
  end

  assign enable_o = out_en_reg;
  assign data_o   = out_data_reg;
  assign busy_o   = gnt_active;

endmodule
